// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped 8-bit input-capture port with a 4-deep
// change FIFO, a 32-bit output register and a status/control register.
// Optional build macro IO_PORT_IRQ_EN adds the irq_en control bit and a
// registered input-pending interrupt; without it irq is tied low.
module io_port_responder #(
  parameter logic [31:0] PORT_OUT_ADDR = 32'h1001_0024,
  parameter logic [31:0] PORT_IN_ADDR  = 32'h1001_0028,
  parameter logic [31:0] STATUS_ADDR   = 32'h1001_002C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic [31:0] PortOut,
  output logic        Hit,
  output logic        irq
);

  logic [7:0]  sync1_q, sync2_q, last_in_q;
  logic [7:0]  mem_q [0:3];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic [31:0] portout_q;
  logic        irq_en_w;

  logic hit_out, hit_in, hit_st;
  logic empty, full, chg, push, pop, drop;
  logic [7:0] head;

  assign hit_out = (Address == PORT_OUT_ADDR);
  assign hit_in  = (Address == PORT_IN_ADDR);
  assign hit_st  = (Address == STATUS_ADDR);
  assign Hit     = hit_out | hit_in | hit_st;

  assign empty = (count_q == 3'd0);
  assign full  = (count_q == 3'd4);
  assign chg   = (sync2_q != last_in_q);
  assign pop   = MemRead & hit_in & ~empty;
  // A pop in the same cycle frees a slot, so a change is accepted even when full.
  assign push  = chg & (~full | pop);
  assign drop  = chg & full & ~pop;
  assign head  = mem_q[rd_ptr_q];

  assign PortOut = portout_q;

  // Occupancy and overflow next-state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (MemWrite && hit_st && WriteData[3]) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
  end

  // Load data mux; zero unless a qualified read hits one of the registers.
  always_comb begin
    ReadData = 32'd0;
    if (MemRead) begin
      if (hit_out)
        ReadData = portout_q;
      else if (hit_in)
        ReadData = empty ? {24'd0, sync2_q} : {24'd0, head};
      else if (hit_st)
        ReadData = {26'd0, irq_en_w, overflow_q, full, empty, count_q[1:0]};
    end
  end

  // Two-flop synchronizer and change detector on the external pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 8'd0;
      sync2_q   <= 8'd0;
      last_in_q <= 8'd0;
    end else begin
      sync1_q <= PortIn;
      sync2_q <= sync1_q;
      if (chg) last_in_q <= sync2_q;
    end
  end

  // FIFO pointers, count and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sync2_q;
  end

  // Output-port register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      portout_q <= 32'd0;
    else if (MemWrite && hit_out)
      portout_q <= WriteData;
  end

`ifdef IO_PORT_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en_w = irq_en_q;
  assign irq      = irq_q;

  // Interrupt enable and registered input-pending interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (MemWrite && hit_st) irq_en_q <= WriteData[5];
      irq_q <= irq_en_q & ~empty;
    end
  end
`else
  assign irq_en_w = 1'b0;
  assign irq      = 1'b0;
`endif

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 Parameter PORT_OUT_ADDR, default 32'h1001_0024: word address of the output-port register.
REQ-002 Parameter PORT_IN_ADDR, default 32'h1001_0028: word address of the input-capture FIFO head.
REQ-003 Parameter STATUS_ADDR, default 32'h1001_002C: word address of the status/control register.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port Address, input, 32: processor data address (ALU result).
REQ-007 Port WriteData, input, 32: store data (Rt).
REQ-008 Port MemWrite, input, 1: store strobe, sampled on clk.
REQ-009 Port MemRead, input, 1: load strobe, qualifies ReadData and pop.
REQ-010 Port PortIn, input, 8: asynchronous external input pins.
REQ-011 Port ReadData, output, 32: load data, combinational from Address/MemRead.
REQ-012 Port PortOut, output, 32: registered output-port value.
REQ-013 Port Hit, output, 1: Address matches any of the three addresses; steers processor read mux.
REQ-014 Port irq, output, 1: input-data-pending interrupt.

Function
REQ-015 PortIn passes a 2-flop synchronizer; capture logic uses only the synchronized value (sync2).
REQ-016 A change detector holds last_in; when sync2 != last_in, it pushes sync2 into a 4-entry FIFO and sets last_in <= sync2 in the same cycle.
REQ-017 FIFO: 4 x 8 bits, 2-bit read/write pointers wrapping 3->0, 3-bit count 0..4.
REQ-018 Store with Address==PORT_OUT_ADDR loads PortOut <= WriteData at the next edge; PortOut is visible one cycle after the store.
REQ-019 Load with Address==PORT_IN_ADDR: ReadData = {24'b0, FIFO head} in the same cycle; the head pops at the edge.
REQ-020 Load of PORT_IN_ADDR when empty: ReadData = {24'b0, sync2}; no pop; count stays 0.
REQ-021 Load with Address==STATUS_ADDR: ReadData = {26'b0, irq_en, overflow, full, empty, count[1:0]}; count 4 reads as full=1, count[1:0]=0.
REQ-022 Load with Address==PORT_OUT_ADDR returns PortOut.
REQ-023 ReadData = 0 when MemRead=0 or Hit=0.
REQ-024 Push when full without a simultaneous pop: data dropped, sticky overflow <= 1.
REQ-025 Simultaneous push and pop: both occur, count unchanged, no overflow, including when full.
REQ-026 Store to STATUS_ADDR: WriteData[3]=1 clears overflow; WriteData[5] loads irq_en; other bits ignored.
REQ-027 Stores or loads to non-matching addresses have no effect on any state.
REQ-028 MemWrite and MemRead both high on the same address: the write takes effect and a PORT_IN pop still occurs.

Reset
REQ-029 While reset=0: PortOut=0, FIFO pointers=0, count=0, overflow=0, irq_en=0, sync flops=0, last_in=0, irq=0.
REQ-030 Assertion mid-operation aborts any pending push/pop immediately; FIFO contents are discarded.
REQ-031 After release, a nonzero PortIn yields its first push 3 edges later (2 sync stages plus change detect).

Configuration
REQ-032 Macro IO_PORT_IRQ_EN defined: irq = irq_en & ~empty, registered (one-cycle delay after a push).
REQ-033 Macro IO_PORT_IRQ_EN undefined: irq tied 0, irq_en flop removed, status bit 5 reads 0, and stores to bit 5 are ignored.

Verification
REQ-034 Store 32'hA5A5_0F0F to 0x1001_0024 -> PortOut=32'hA5A5_0F0F next cycle; load of 0x1001_0024 returns the same value.
REQ-035 PortIn 0x00->0x3C, then hold -> exactly one push; status=0x01 (count 1); load 0x1001_0028 returns 0x0000003C, then status=0x04 (empty).
REQ-036 Five distinct PortIn changes, no loads -> status full=1, overflow=1 (0x18); FIFO holds the first four; store 0x08 to status -> overflow=0.
REQ-037 FIFO full, PortIn change in the same cycle as a load of 0x1001_0028 -> oldest entry returned, count stays 4, overflow stays 0.
REQ-038 IO_PORT_IRQ_EN defined, irq_en=1, one push -> irq=1 one cycle later; pop -> irq=0; reset=0 mid-push -> all outputs 0 asynchronously.
